// File: rtl/acc_requant_if.sv
// ==========================================================================
// acc_requant_if : handshake, config and status bundle for acc_requant. rev 1.0
// ==========================================================================
`default_nettype none

interface acc_requant_if #(
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 8,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 16
);
  logic                      in_valid;
  logic                      in_ready;
  logic signed [ACC_W-1:0]   in_acc;
  logic                      in_last;
  logic signed [ACC_W-1:0]   cfg_bias;
  logic        [MULT_W-1:0]  cfg_mult;
  logic        [SHIFT_W-1:0] cfg_shift;
  logic signed [OUT_W-1:0]   cfg_zp;
  logic                      cfg_relu;
  logic                      out_valid;
  logic                      out_ready;
  logic signed [OUT_W-1:0]   out_data;
  logic                      out_last;
  logic                      out_sat;
  logic        [CNT_W-1:0]   sat_cnt;
  logic                      sat_clr;

  modport master (
    output in_valid, in_acc, in_last, cfg_bias, cfg_mult, cfg_shift, cfg_zp, cfg_relu,
    output out_ready, sat_clr,
    input  in_ready, out_valid, out_data, out_last, out_sat, sat_cnt
  );

  modport slave (
    input  in_valid, in_acc, in_last, cfg_bias, cfg_mult, cfg_shift, cfg_zp, cfg_relu,
    input  out_ready, sat_clr,
    output in_ready, out_valid, out_data, out_last, out_sat, sat_cnt
  );
endinterface

`default_nettype wire

// File: rtl/acc_requant.sv
// ==========================================================================
// acc_requant : bias, scale, rounding shift, ReLU, zero point, int8 clamp. rev 1.0
// ==========================================================================
`default_nettype none

module acc_requant #(
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 8,
  parameter int MULT_W  = 16,
  parameter int SHIFT_W = 5,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  acc_requant_if.slave bus
);
  localparam int S1_W  = ACC_W + 1;
  localparam int S2_W  = ACC_W + MULT_W + 1;
  localparam int RND_W = S2_W + 1;
  localparam int V_W   = RND_W + 1;
  localparam logic signed [V_W-1:0] OUT_MAX = V_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [V_W-1:0] OUT_MIN = ~OUT_MAX;

  logic adv1, adv2, adv3;

  logic                      v1, last1, relu1;
  logic signed [S1_W-1:0]    s1;
  logic        [MULT_W-1:0]  mult1;
  logic        [SHIFT_W-1:0] shift1;
  logic signed [OUT_W-1:0]   zp1;

  logic                      v2, last2, relu2;
  logic signed [S2_W-1:0]    s2;
  logic        [SHIFT_W-1:0] shift2;
  logic signed [OUT_W-1:0]   zp2;

  logic                      v3, last3, sat3;
  logic signed [OUT_W-1:0]   data3;
  logic        [CNT_W-1:0]   cnt;

  logic signed [S1_W-1:0]    sum1;
  logic signed [S2_W-1:0]    s1_ext, mult_ext, prod;
  logic signed [RND_W-1:0]   s2_ext, half, rounded;
  logic signed [V_W-1:0]     biased, zp_ext;
  logic signed [OUT_W-1:0]   data_nxt;
  logic                      sat_nxt;

  // Bubbles collapse: a stage may load whenever the one ahead of it can move.
  assign adv3 = ~v3 | bus.out_ready;
  assign adv2 = ~v2 | adv3;
  assign adv1 = ~v1 | adv2;

  assign sum1     = $signed({bus.in_acc[ACC_W-1], bus.in_acc})
                  + $signed({bus.cfg_bias[ACC_W-1], bus.cfg_bias});
  assign s1_ext   = {{(S2_W - S1_W){s1[S1_W-1]}}, s1};
  assign mult_ext = {{(S2_W - MULT_W){1'b0}}, mult1};
  assign prod     = s1_ext * mult_ext;

  always_comb begin
    half = '0;
    if (shift2 != '0) half[shift2 - 1'b1] = 1'b1;
    s2_ext  = {s2[S2_W-1], s2};
    rounded = (s2_ext + half) >>> shift2;
    if (relu2 && rounded < 0) rounded = '0;
    zp_ext  = {{(V_W - OUT_W){zp2[OUT_W-1]}}, zp2};
    biased  = {rounded[RND_W-1], rounded} + zp_ext;
    sat_nxt = 1'b0;
    if (biased > OUT_MAX) begin
      data_nxt = OUT_MAX[OUT_W-1:0];
      sat_nxt  = 1'b1;
    end else if (biased < OUT_MIN) begin
      data_nxt = OUT_MIN[OUT_W-1:0];
      sat_nxt  = 1'b1;
    end else begin
      data_nxt = biased[OUT_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0; last1 <= 1'b0; relu1 <= 1'b0;
      s1 <= '0; mult1 <= '0; shift1 <= '0; zp1 <= '0;
    end else if (adv1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        s1     <= sum1;
        mult1  <= bus.cfg_mult;
        shift1 <= bus.cfg_shift;
        zp1    <= bus.cfg_zp;
        relu1  <= bus.cfg_relu;
        last1  <= bus.in_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0; last2 <= 1'b0; relu2 <= 1'b0;
      s2 <= '0; shift2 <= '0; zp2 <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        s2     <= prod;
        shift2 <= shift1;
        zp2    <= zp1;
        relu2  <= relu1;
        last2  <= last1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3 <= 1'b0; last3 <= 1'b0; sat3 <= 1'b0; data3 <= '0;
    end else if (adv3) begin
      v3 <= v2;
      if (v2) begin
        data3 <= data_nxt;
        sat3  <= sat_nxt;
        last3 <= last2;
      end
    end
  end

  // Clear wins over a coincident increment; the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (bus.sat_clr) begin
      cnt <= '0;
    end else if (v3 && bus.out_ready && sat3 && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = v3;
  assign bus.out_data  = data3;
  assign bus.out_last  = last3;
  assign bus.out_sat   = sat3;
  assign bus.sat_cnt   = cnt;

endmodule

`default_nettype wire
